// File: rtl/uart_rx_cfg.sv
// UART receiver with parameterised frame format and 16x oversampling.
// Holds one received word (with its error flags) until the consumer accepts it.
module uart_rx_cfg #(
  parameter int C_CLKFREQ   = 100_000_000,
  parameter int C_BAUDRATE  = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 rx_ready_i,
  output logic [DATA_BITS-1:0] rx_dout_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 rx_active_o
);
  localparam int DIV   = C_CLKFREQ / (C_BAUDRATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       DBITS_L   = 4'(DATA_BITS);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 ovr_q, ovr_d;

  logic rx_s, tick, mid, last, vote, exp_par, complete;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_d[gi] = rx_i;
    end else begin : g_next
      assign sync_d[gi] = sync_q[gi-1];
    end
  end

  assign rx_s    = sync_q[1];
  assign tick    = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign mid     = tick && (tick_cnt_q == 4'd9);
  assign last    = tick && (tick_cnt_q == 4'd15);
  // Majority of ticks 7, 8 and the live sample at tick 9.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign exp_par = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = rx_s;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = 1'b0;
    complete   = 1'b0;

    // Counters idle at zero so a new frame always starts from a clean phase.
    if (state_q == S_IDLE) begin
      div_d      = '0;
      tick_cnt_d = 4'd0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
    end
    if (tick && tick_cnt_q == 4'd7) samp_d[0] = rx_s;
    if (tick && tick_cnt_q == 4'd8) samp_d[1] = rx_s;

    case (state_q)
      S_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d   = S_START;
          bit_d     = 4'd0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      S_START: begin
        if (mid && vote) state_d = S_IDLE;
        else if (last)   state_d = S_DATA;
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
        end else if (last && bit_q == DBITS_L) begin
          bit_d   = 4'd0;
          state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid)       par_err_d = (vote != exp_par);
        else if (last) state_d   = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          if (!vote) frm_err_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (valid_q && rx_ready_i) valid_d = 1'b0;
    // The last stop-bit vote is folded in directly since frm_err_q updates only next cycle.
    if (complete) begin
      if (!valid_q || rx_ready_i) begin
        dout_d     = shift_q;
        perr_out_d = par_err_q;
        ferr_out_d = frm_err_q | ~vote;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      div_q      <= '0;
      tick_cnt_q <= 4'd0;
      samp_q     <= 2'b00;
      bit_q      <= 4'd0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_dout_o    = dout_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign overrun_o    = ovr_q;
  assign rx_active_o  = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter C_CLKFREQ, default 100_000_000, SHALL set the clock frequency in Hz.
REQ-003 Parameter C_BAUDRATE, default 115_200, SHALL set the line bit rate in Hz.
REQ-004 Parameter DATA_BITS, default 8, SHALL set data bits per frame (legal 5..9).
REQ-005 Parameter PARITY_MODE, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-006 Parameter STOP_BITS, default 1, SHALL set stop bits per frame (legal 1 or 2).
REQ-007 Port clk_i, input, width 1, SHALL be the clock.
REQ-008 Port rst_i, input, width 1, SHALL be the asynchronous active-high reset.
REQ-009 Port rx_i, input, width 1, SHALL be the asynchronous serial line (idle high).
REQ-010 Port rx_ready_i, input, width 1, SHALL be the consumer accept signal.
REQ-011 Port rx_dout_o, output, width DATA_BITS, SHALL carry the received word, LSB first on the line.
REQ-012 Port rx_valid_o, output, width 1, SHALL mark rx_dout_o and the error flags as holding a frame.
REQ-013 Port parity_err_o, output, width 1, SHALL flag a parity mismatch for the held frame.
REQ-014 Port frame_err_o, output, width 1, SHALL flag a low stop bit for the held frame.
REQ-015 Port overrun_o, output, width 1, SHALL pulse for one cycle when a completed frame is dropped.
REQ-016 Port rx_active_o, output, width 1, SHALL be high while the FSM is in any state other than IDLE.

Function
REQ-017 rx_i SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-018 A tick strobe SHALL fire every DIV = C_CLKFREQ/(C_BAUDRATE*16) cycles (integer division); elaboration SHALL fail if DIV < 2 or any parameter is outside its legal range.
REQ-019 Each bit period SHALL be 16 ticks, counted 0..15; the bit value SHALL be the majority vote of the samples taken at ticks 7, 8 and 9, and SHALL be decided at tick 9.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE->START on a synchronized high-to-low transition; the tick divider and tick counter SHALL restart at 0 on entry.
REQ-022 In START, a voted 1 SHALL return the FSM to IDLE (glitch rejection) with no output; a voted 0 SHALL move it to DATA at tick 15.
REQ-023 DATA SHALL shift in DATA_BITS bits, LSB first, then move to PARITY if PARITY_MODE!=0, else to STOP.
REQ-024 PARITY SHALL compare the voted bit with the XOR of the data (even) or its inverse (odd); mismatch SHALL set the pending parity error.
REQ-025 STOP SHALL check STOP_BITS bits; any voted 0 SHALL set the pending frame error.
REQ-026 The final stop bit SHALL complete the frame at its tick 9, and the FSM SHALL enter IDLE on the next cycle so that an early next start edge is caught.
REQ-027 On completion, if rx_valid_o is 0, or rx_valid_o and rx_ready_i are both 1, then the word and both error flags SHALL load the output register and rx_valid_o SHALL be 1 on the next cycle.
REQ-028 On completion, if rx_valid_o is 1 and rx_ready_i is 0, the new frame SHALL be discarded, the held frame SHALL be unchanged, and overrun_o SHALL pulse for 1 cycle.
REQ-029 rx_valid_o SHALL clear on the cycle after rx_valid_o and rx_ready_i are both 1 with no completion that cycle; rx_dout_o SHALL hold its value until the next load.
REQ-030 Frames with errors SHALL still be delivered, with their flags set.
REQ-031 Latency SHALL be 1 clk from the final stop-bit decision to rx_valid_o rising (rx_i to FSM: +2 synchronizer cycles).

Reset
REQ-032 While rst_i is high: FSM in IDLE, all counters 0, synchronizer flops 1, and rx_dout_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o, rx_active_o all 0.
REQ-033 Reset mid-frame SHALL abandon the partial frame; the first falling edge after release SHALL start a new frame.

Verification (C_CLKFREQ=32_000_000, C_BAUDRATE=1_000_000: DIV=2, 32 clk/bit)
REQ-034 8N1 frame carrying 0xA5, rx_ready_i=1 -> rx_valid_o pulses 1 cycle, rx_dout_o=0xA5, both error flags 0.
REQ-035 8E1 frame with 0x07 and parity bit 0 -> rx_dout_o=0x07, parity_err_o=1, frame_err_o=0.
REQ-036 8N1 frame with 0x3C and stop bit 0 -> rx_dout_o=0x3C, frame_err_o=1; the next valid frame 0x11 is received cleanly.
REQ-037 Low glitch of 8 clk on an idle line -> FSM returns to IDLE, no rx_valid_o, rx_active_o high only during the glitch window.
REQ-038 Frames 0x01 then 0x02 with rx_ready_i=0 -> rx_dout_o stays 0x01, one overrun_o pulse at the end of the second frame.
REQ-039 rst_i asserted during the 4th data bit, then frame 0x5A -> all outputs 0 during reset, then rx_dout_o=0x5A with no errors.
